lockstep_sweep_ctrl: RTL and testbench

Sequencing controller for the dual-redundant comparator datapath. It sweeps every operand pair across both comparator channels, waits a programmable settle time, and samples and cross-checks both channels' flag triplets. Transient disagreements are retried; a persistent one raises a latched fault and captures the failing vector. It sits between the counter-driven operand sources and the mismatch-detection logic and replaces free-running stimulus with a deterministic, restartable self-test.

---
 rtl/lockstep_sweep_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_lockstep_sweep_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockstep_sweep_ctrl.sv
// lockstep_sweep_ctrl
// Self-test sequencer for the dual-redundant comparator datapath. It walks
// every (vec_a, vec_b) operand pair through both comparator channels, lets
// the channels settle, then cross-checks the two {lt,gt,eq} flag triplets.
// A failing sample is retried up to MAX_RETRY times. A vector that keeps
// failing latches fault and captures the failing pair in fail_a/fail_b.
//
// Optional feature macro: LOCKSTEP_GOLDEN_CHECK_EN
//   When defined, channel 0 is also compared against a locally computed
//   expected triplet. This catches common-mode errors that make both
//   channels wrong in the same way.

module lockstep_sweep_ctrl #(
  parameter int WIDTH     = 4,
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       ch0_flags,
  input  logic [2:0]       ch1_flags,
  output logic [WIDTH-1:0] vec_a,
  output logic [WIDTH-1:0] vec_b,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [7:0]       err_cnt,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam logic [3:0]         SETTLE_INIT = 4'(SETTLE);
  localparam logic [2:0]         RETRY_LIMIT = 3'(MAX_RETRY);
  localparam logic [2*WIDTH-1:0] VEC_STEP    = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   VEC_ZERO    = {WIDTH{1'b0}};

  state_t             state_r;
  logic [3:0]         settle_cnt_r;
  logic [2:0]         retry_cnt_r;

  logic               cross_fail_s;
  logic               golden_fail_s;
  logic               sample_fail_s;
  logic               last_vec_s;
  logic               retry_ok_s;
  logic [7:0]         err_next_s;
  logic [2*WIDTH-1:0] vec_next_s;

  // A valid comparator result has exactly one of lt/gt/eq set.
  function automatic logic is_onehot3(input logic [2:0] f);
    case (f)
      3'b001, 3'b010, 3'b100: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

`ifdef LOCKSTEP_GOLDEN_CHECK_EN
  // Reference comparator result for the operand pair currently driven.
  function automatic logic [2:0] golden_flags(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    return {(a < b), (a > b), (a == b)};
  endfunction

  assign golden_fail_s = (ch0_flags != golden_flags(vec_a, vec_b));
`else
  assign golden_fail_s = 1'b0;
`endif

  // Classify the current sample and precompute the next vector and count.
  always_comb begin
    cross_fail_s  = (ch0_flags != ch1_flags) |
                    ~is_onehot3(ch0_flags) |
                    ~is_onehot3(ch1_flags);
    sample_fail_s = cross_fail_s | golden_fail_s;
    last_vec_s    = (&vec_a) & (&vec_b);
    retry_ok_s    = (retry_cnt_r < RETRY_LIMIT);
    vec_next_s    = {vec_a, vec_b} + VEC_STEP;
    if (err_cnt == 8'hFF) begin
      err_next_s = err_cnt;
    end else begin
      err_next_s = err_cnt + 8'd1;
    end
  end

  // Sweep sequencer: the state, vector, counters and all outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= 4'd0;
      retry_cnt_r  <= 3'd0;
      vec_a        <= VEC_ZERO;
      vec_b        <= VEC_ZERO;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      err_cnt      <= 8'd0;
      fail_a       <= VEC_ZERO;
      fail_b       <= VEC_ZERO;
    end else begin
      case (state_r)
        ST_IDLE, ST_FAULT: begin
          // abort is not looked at here, so start wins if both are high.
          if (start) begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= SETTLE_INIT;
            retry_cnt_r  <= 3'd0;
            vec_a        <= VEC_ZERO;
            vec_b        <= VEC_ZERO;
            busy         <= 1'b1;
            done         <= 1'b0;
            fault        <= 1'b0;
            err_cnt      <= 8'd0;
            fail_a       <= VEC_ZERO;
            fail_b       <= VEC_ZERO;
          end
        end

        ST_SETTLE: begin
          if (abort) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= 4'd0;
            retry_cnt_r  <= 3'd0;
            vec_a        <= VEC_ZERO;
            vec_b        <= VEC_ZERO;
            busy         <= 1'b0;
          end else begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
            if (settle_cnt_r == 4'd1) begin
              state_r <= ST_SAMPLE;
            end
          end
        end

        ST_SAMPLE: begin
          if (abort) begin
            // abort is checked before the sample, so this sample is dropped.
            state_r      <= ST_IDLE;
            settle_cnt_r <= 4'd0;
            retry_cnt_r  <= 3'd0;
            vec_a        <= VEC_ZERO;
            vec_b        <= VEC_ZERO;
            busy         <= 1'b0;
          end else if (sample_fail_s) begin
            err_cnt <= err_next_s;
            if (retry_ok_s) begin
              // Treat as possibly transient: settle again on the same vector.
              retry_cnt_r  <= retry_cnt_r + 3'd1;
              settle_cnt_r <= SETTLE_INIT;
              state_r      <= ST_SETTLE;
            end else begin
              fail_a  <= vec_a;
              fail_b  <= vec_b;
              fault   <= 1'b1;
              busy    <= 1'b0;
              state_r <= ST_FAULT;
            end
          end else begin
            retry_cnt_r <= 3'd0;
            if (last_vec_s) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              {vec_a, vec_b} <= vec_next_s;
              settle_cnt_r   <= SETTLE_INIT;
              state_r        <= ST_SETTLE;
            end
          end
        end

        ST_DONE: begin
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lockstep_sweep_ctrl.sv
// Scoreboard bench for lockstep_sweep_ctrl. The channel flags are modelled
// from the driven vectors, with optional fault injection on one target
// vector. The expected outcome of each sweep comes from a closed-form model
// and is queued when the sweep is started. A monitor pops one entry each
// time busy falls.

module tb_lockstep_sweep_ctrl;

  localparam int WIDTH     = 4;
  localparam int SETTLE    = 2;
  localparam int MAX_RETRY = 2;
  localparam int PER       = SETTLE + 1;
  localparam int NVEC      = 1 << (2 * WIDTH);
  localparam int VMAX      = (1 << WIDTH) - 1;
`ifdef LOCKSTEP_GOLDEN_CHECK_EN
  localparam bit GOLD = 1'b1;
`else
  localparam bit GOLD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [2:0]       ch0_flags;
  logic [2:0]       ch1_flags;
  logic [WIDTH-1:0] vec_a;
  logic [WIDTH-1:0] vec_b;
  logic             busy;
  logic             done;
  logic             fault;
  logic [7:0]       err_cnt;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;

  lockstep_sweep_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .ch0_flags(ch0_flags), .ch1_flags(ch1_flags),
    .vec_a(vec_a), .vec_b(vec_b), .busy(busy), .done(done), .fault(fault),
    .err_cnt(err_cnt), .fail_a(fail_a), .fail_b(fail_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int busy_cyc;
    int done;
    int fault;
    int err;
    int fa;
    int fb;
    int va;
    int vb;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Ideal comparator behaviour {lt,gt,eq}.
  function automatic logic [2:0] ref_flags(input int a, input int b);
    if (a < b) return 3'b100;
    if (a > b) return 3'b010;
    return 3'b001;
  endfunction

  // Fault injection: corrupt the first inj_k samples of vector (inj_a, inj_b).
  // mode 1 = ch1 shows inj_val, mode 2 = both channels show gt.
  int         inj_a    = 0;
  int         inj_b    = 0;
  int         inj_k    = 0;
  int         inj_mode = 0;
  logic [2:0] inj_val  = 3'b000;
  int         hits     = 0;
  logic [2:0] ideal_s;
  logic       corrupt;

  assign ideal_s   = ref_flags(int'(vec_a), int'(vec_b));
  assign corrupt   = (inj_mode != 0) && (hits >= 1) && (hits <= inj_k * PER);
  assign ch0_flags = (corrupt && inj_mode == 2) ? 3'b010 : ideal_s;
  assign ch1_flags = corrupt ? ((inj_mode == 1) ? inj_val : 3'b010) : ideal_s;

  // Count the busy cycles spent on the target vector. Each sample covers PER cycles.
  always @(negedge clk) begin
    if (busy && int'(vec_a) == inj_a && int'(vec_b) == inj_b) hits = hits + 1;
    else hits = 0;
  end

  // Sweep-level prediction from the number of failing samples on the target.
  function automatic exp_t predict(input int a, input int b, input int k, input int mode);
    exp_t e;
    int   fails;
    fails = 0;
    if (mode == 1) fails = k;
    else if (mode == 2 && GOLD && ref_flags(a, b) != 3'b010) fails = k;
    if (fails > MAX_RETRY) begin
      e.busy_cyc = (a * (VMAX + 1) + b + MAX_RETRY + 1) * PER;
      e.done = 0; e.fault = 1; e.err = MAX_RETRY + 1;
      e.fa = a; e.fb = b; e.va = a; e.vb = b;
    end else begin
      e.busy_cyc = (NVEC + fails) * PER;
      e.done = 1; e.fault = 0; e.err = fails;
      e.fa = 0; e.fb = 0; e.va = VMAX; e.vb = VMAX;
    end
    return e;
  endfunction

  // Monitor: measure busy time and compare the end-of-sweep outputs.
  int   busy_cnt  = 0;
  bit   prev_busy = 1'b0;
  bit   done_chk  = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (done_chk) begin
      check("done_one_cycle", int'(done), 0);
      done_chk = 1'b0;
    end
    if (busy) begin
      busy_cnt++;
    end else if (prev_busy) begin
      if (sb_q.size() == 0) begin
        check("unexpected_end", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("busy_cycles", busy_cnt, mon_e.busy_cyc);
        check("done", int'(done), mon_e.done);
        check("fault", int'(fault), mon_e.fault);
        check("err_cnt", int'(err_cnt), mon_e.err);
        check("fail_a", int'(fail_a), mon_e.fa);
        check("fail_b", int'(fail_b), mon_e.fb);
        check("vec_a", int'(vec_a), mon_e.va);
        check("vec_b", int'(vec_b), mon_e.vb);
        if (mon_e.done != 0) done_chk = 1'b1;
      end
      busy_cnt = 0;
    end
    prev_busy = busy;
  end

  task automatic issue_start(input bit with_abort);
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_fault_clr", int'(fault), 0);
    check("start_err_clr", int'(err_cnt), 0);
    check("start_vec", int'({vec_a, vec_b}), 0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && $urandom_range(0, 63) == 0) start = 1'b1;
      n++;
    end
    start = 1'b0;
    if (n >= budget) begin
      check("sweep_timeout", 1, 0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      sb_q.delete();
    end
  endtask

  task automatic run_sweep(input int a, input int b, input int k, input int mode,
                           input logic [2:0] val);
    exp_t e;
    inj_a = a; inj_b = b; inj_k = k; inj_mode = mode; inj_val = val;
    e = predict(a, b, k, mode);
    sb_q.push_back(e);
    issue_start(1'($urandom_range(0, 1)));
    wait_idle(e.busy_cyc + 50);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_abort(input int n);
    exp_t e;
    inj_mode = 0;
    e.busy_cyc = n; e.done = 0; e.fault = 0; e.err = 0;
    e.fa = 0; e.fb = 0; e.va = 0; e.vb = 0;
    sb_q.push_back(e);
    issue_start(1'b0);
    repeat (n - 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_reset(input int n);
    exp_t e;
    inj_a = 1; inj_b = 2; inj_k = 2; inj_mode = 1; inj_val = 3'b001;
    e.busy_cyc = n; e.done = 0; e.fault = 0; e.err = 0;
    e.fa = 0; e.fb = 0; e.va = 0; e.vb = 0;
    sb_q.push_back(e);
    issue_start(1'b0);
    repeat (n - 1) @(negedge clk);
    check("pre_reset_err", int'(err_cnt), 2);
    #1 reset = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_vec", int'({vec_a, vec_b}), 0);
    check("rst_err", int'(err_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    inj_mode = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_fault", int'(fault), 0);
    check("reset_err", int'(err_cnt), 0);
    check("reset_vec", int'({vec_a, vec_b}), 0);
    check("reset_fail", int'({fail_a, fail_b}), 0);
    reset = 1'b1;
    @(negedge clk);

    run_sweep(0, 0, 0, 0, 3'b000);     // clean sweep
    run_sweep(3, 5, 255, 1, 3'b001);   // persistent ch1 error
    run_sweep(7, 7, 1, 1, 3'b100);     // single transient
    run_abort(100);
    run_reset(300);
    run_sweep(0, 0, 0, 0, 3'b000);     // full sweep after reset
    run_sweep(2, 9, 255, 2, 3'b010);   // common-mode gt on (2,9)

    for (int i = 0; i < 6; i++) begin
      int a, b, k, mode;
      logic [2:0] v;
      a    = $urandom_range(0, VMAX);
      b    = $urandom_range(0, VMAX);
      k    = $urandom_range(0, 4);
      mode = $urandom_range(1, 2);
      do v = 3'($urandom_range(0, 7)); while (v == ref_flags(a, b));
      run_sweep(a, b, k, mode, v);
    end
    run_abort($urandom_range(5, 400));

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
